ram_ctrl_multi: RTL
===================

Name: ram_ctrl_multi

Overview:
- Parametrised successor to the scope's fixed 3-channel RAM interface.
- Owns the shared sample-RAM control bus (en/we/addr) for NUM_CH channel RAMs and maintains a circular capture write pointer with a wrap flag.
- Sequences dump readout of one selected channel, oldest sample first, through a valid/ready handshake to the dump consumer (UART/command path).
- Sits between the capture SM, the dump SM and the per-channel RAM instances.

Parameters:
- NUM_CH, 3, number of channel RAMs (1..7).
- DATA_W, 8, sample width.
- ADDR_W, 9, RAM address width; buffer depth = 2**ADDR_W.
- RD_LAT, 1, RAM read latency in clocks (1..3).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cap_wr  in  1  capture SM writes one sample this cycle (all channels in parallel).
- cap_clr  in  1  clear write pointer and wrap flag; honoured only when idle.
- dump_start  in  1  one-cycle request to dump the channel given on dump_ch.
- dump_ch  in  $clog2(NUM_CH+1)  channel select; 1..NUM_CH are valid, 0 means none.
- dump_rdy  in  1  consumer accepts dump_data.
- ch_rdata  in  NUM_CH*DATA_W  RAM read data; channel k occupies bits [k*DATA_W-1 -: DATA_W].
- ram_en  out  1  RAM enable, shared by all channels.
- ram_we  out  1  RAM write enable, shared by all channels.
- ram_addr  out  ADDR_W  RAM address, shared by all channels.
- dump_data  out  DATA_W  registered read sample.
- dump_vld  out  1  dump_data is valid.
- dump_done  out  1  one-cycle pulse after the last sample is accepted.
- busy  out  1  dump in progress.
- cap_err  out  1  one-cycle pulse when cap_wr is dropped.
- wr_ptr  out  ADDR_W  next write address.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; wr_ptr=0, wrapped=0, dump_data=0, and all flag outputs 0.
- Capture write path:
  - In IDLE, ram_en = ram_we = cap_wr (combinational) and ram_addr = wr_ptr.
  - On each cap_wr, wr_ptr increments modulo 2**ADDR_W. If wr_ptr was 2**ADDR_W-1, wrapped is set and stays set.
- cap_wr when busy=1: no RAM write, wr_ptr unchanged, cap_err pulses on the next cycle.
- cap_clr in IDLE: wr_ptr=0, wrapped=0. If cap_wr and cap_clr are asserted together, cap_clr wins and no write occurs. cap_clr when busy is ignored.
- Dump length and start address:
  - wrapped=1: length = 2**ADDR_W, start address = wr_ptr (oldest sample).
  - wrapped=0: length = wr_ptr, start address = 0.
- dump_start acceptance (IDLE only):
  - dump_ch must be in 1..NUM_CH; otherwise the request is ignored and busy stays 0.
  - The channel is latched at accept; later changes to dump_ch have no effect on the dump in progress.
  - Length 0: no RAM access and no busy; dump_done pulses on the next cycle.
  - dump_start while busy is ignored.
- State machine: IDLE -> RD -> WAIT -> HOLD -> (RD | DONE) -> IDLE.
  - RD: one cycle; ram_en=1, ram_we=0, ram_addr=rd_ptr.
  - WAIT: RD_LAT cycles. On the last WAIT cycle, dump_data <= the latched channel's slice of ch_rdata.
  - HOLD: dump_vld=1 and dump_data stable until dump_rdy. On the accepting cycle, rd_ptr increments with wrap and the remaining count decrements. If the remaining count reaches 0, go to DONE, otherwise RD.
  - DONE: dump_done=1 for one cycle, then IDLE.
- busy=1 from the cycle after dump_start is accepted through the DONE cycle.
- ram_en and ram_we are 0 in WAIT, HOLD and DONE.
- The capture pointer is not modified by a dump; a second dump returns identical data.
- Reset asserted mid-dump: everything returns to reset values at the next edge, no further RAM reads, no dump_done.
- dump_rdy outside HOLD is ignored.

Test Plan:
- ADDR_W=4, NUM_CH=3, RD_LAT=1. Write 5 samples (ch2 = 0x10..0x14), then dump ch2 with dump_rdy held high -> dump_data 0x10,0x11,0x12,0x13,0x14, one dump_vld per 3 clocks, dump_done 1 cycle after the last accept, wr_ptr=5.
- Write 20 samples (ch1 value = index) -> wrapped=1, wr_ptr=4. Dump ch1 -> 16 samples 4..19 (hex 0x04..0x13), ram_addr sequence 4..15,0..3.
- Dump ch3 while the consumer toggles dump_rdy 0/1 on alternate cycles -> dump_data is held stable across every stall, no sample lost or duplicated; repeat with RD_LAT=3 -> same data, 2 extra cycles per sample.
- Pulse cap_wr mid-dump -> ram_we stays 0, cap_err pulses once, wr_ptr unchanged.
- dump_start with dump_ch=0 -> no busy, no RAM access.
- After reset or cap_clr, dump ch1 -> dump_done only, with no dump_vld.
- Assert rst_n=0 during HOLD of sample 7 -> next cycle: busy=0, dump_vld=0, wr_ptr=0, ram_en=0, no dump_done.
- cap_wr and cap_clr in the same IDLE cycle -> ram_we=0, wr_ptr=0.

Source files
------------

// File: rtl/ram_ctrl_multi.sv
// ram_ctrl_multi
//   Shared sample-RAM controller for NUM_CH channel RAMs. Maintains the
//   circular capture write pointer and its wrap flag. Sequences an
//   oldest-first dump of one selected channel through a valid/ready
//   handshake.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cap_wr, cap_clr       capture write strobe / pointer clear (idle only)
//   dump_start, dump_ch   dump request and channel select (1..NUM_CH, 0 = none)
//   dump_rdy              consumer accepts dump_data
//   ch_rdata              RAM read data; channel k at [k*DATA_W-1 -: DATA_W]
//   ram_en/ram_we/ram_addr  shared RAM control bus
//   dump_data, dump_vld   registered dump sample and its valid flag
//   dump_done             one-cycle pulse after the final accept
//   busy                  dump in progress
//   cap_err               one-cycle pulse when a capture write was dropped
//   wr_ptr                next capture write address
module ram_ctrl_multi #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cap_wr,
  input  logic                         cap_clr,
  input  logic                         dump_start,
  input  logic [$clog2(NUM_CH+1)-1:0]  dump_ch,
  input  logic                         dump_rdy,
  input  logic [NUM_CH*DATA_W-1:0]     ch_rdata,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            dump_data,
  output logic                         dump_vld,
  output logic                         dump_done,
  output logic                         busy,
  output logic                         cap_err,
  output logic [ADDR_W-1:0]            wr_ptr
);

  localparam int CH_W  = $clog2(NUM_CH+1);
  localparam int CNT_W = ADDR_W + 1;
  localparam int LAT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t             state;
  logic               wrapped;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]   remain;
  logic [CH_W-1:0]    ch_sel;
  logic [LAT_W-1:0]   lat_cnt;

  logic               wr_fire;
  logic               clr_fire;
  logic               ch_ok;
  logic [CNT_W-1:0]   dump_len;
  logic [ADDR_W-1:0]  dump_base;
  logic [DATA_W-1:0]  sel_data;

  // Capture strobes are only honoured in IDLE; clear beats write.
  always_comb begin
    wr_fire  = (state == S_IDLE) && cap_wr && !cap_clr;
    clr_fire = (state == S_IDLE) && cap_clr;
    ch_ok    = (dump_ch != '0) && (dump_ch <= CH_W'(NUM_CH));
  end

  // Once wrapped the whole buffer is valid and the oldest sample sits at
  // the write pointer; before that the samples run from address 0.
  always_comb begin
    if (wrapped) begin
      dump_len  = {1'b1, {ADDR_W{1'b0}}};
      dump_base = wr_ptr;
    end else begin
      dump_len  = {1'b0, wr_ptr};
      dump_base = '0;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      if (ch_sel == CH_W'(k)) begin
        sel_data = ch_rdata[k*DATA_W-1 -: DATA_W];
      end
    end
  end

  // Shared RAM bus: dump reads own it in RD, capture writes otherwise.
  always_comb begin
    ram_en   = (state == S_RD) || wr_fire;
    ram_we   = wr_fire;
    ram_addr = (state == S_RD) ? rd_ptr : wr_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      rd_ptr    <= '0;
      remain    <= '0;
      ch_sel    <= '0;
      lat_cnt   <= '0;
      dump_data <= '0;
      dump_vld  <= 1'b0;
      dump_done <= 1'b0;
      busy      <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      cap_err   <= cap_wr && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (clr_fire) begin
            wr_ptr  <= '0;
            wrapped <= 1'b0;
          end else if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (&wr_ptr) begin
              wrapped <= 1'b1;
            end
          end
          if (dump_start && ch_ok) begin
            if (dump_len == '0) begin
              // Empty buffer: report completion without touching the RAM.
              dump_done <= 1'b1;
            end else begin
              ch_sel <= dump_ch;
              rd_ptr <= dump_base;
              remain <= dump_len;
              busy   <= 1'b1;
              state  <= S_RD;
            end
          end
        end
        S_RD: begin
          lat_cnt <= LAT_W'(RD_LAT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            dump_data <= sel_data;
            dump_vld  <= 1'b1;
            state     <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (dump_rdy) begin
            dump_vld <= 1'b0;
            rd_ptr   <= rd_ptr + 1'b1;
            remain   <= remain - 1'b1;
            if (remain == CNT_W'(1)) begin
              dump_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          dump_vld <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
